// File: rtl/ysyx_25020047_ifu.sv
// Instruction fetch unit: issues one word read per fetch_start on the
// instruction-memory bus and hands the word to decode over valid/ready.
// One fetch in flight at a time, one-entry hold register, response timeout
// and flush for redirects. Every output is a register.
module ysyx_25020047_ifu #(
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] NOP_INST = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_start,
    input  logic [31:0] pc,
    input  logic        flush,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        imem_rsp_err,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [1:0]  inst_err,
    output logic        busy,
    output logic [31:0] fetch_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    localparam logic [1:0] ERR_OK    = 2'd0;
    localparam logic [1:0] ERR_ALIGN = 2'd1;
    localparam logic [1:0] ERR_BUS   = 2'd2;
    localparam logic [1:0] ERR_TOUT  = 2'd3;

    // The timer value reached on this WAIT cycle is compared with TIMEOUT-1,
    // so the abort lands TIMEOUT cycles after the request was accepted.
    localparam logic [16:0] TOUT_LIMIT = 17'(TIMEOUT) - 17'd1;

    state_t      state_r, state_s;
    logic        drop_r, drop_s;
    logic [15:0] timer_r, timer_s;
    logic        req_valid_r, req_valid_s;
    logic [31:0] req_addr_r, req_addr_s;
    logic        inst_valid_r, inst_valid_s;
    logic [31:0] inst_r, inst_s;
    logic [31:0] inst_pc_r, inst_pc_s;
    logic [1:0]  inst_err_r, inst_err_s;
    logic        busy_r, busy_s;
    logic [31:0] fetch_cnt_r, fetch_cnt_s;
    logic [16:0] timer_inc_s;
    logic        timeout_hit_s;

    assign timer_inc_s   = {1'b0, timer_r} + 17'd1;
    assign timeout_hit_s = (timer_inc_s >= TOUT_LIMIT);

    // Next-state and next-output computation for the fetch FSM.
    always_comb begin
        state_s      = state_r;
        drop_s       = drop_r;
        timer_s      = timer_r;
        req_valid_s  = req_valid_r;
        req_addr_s   = req_addr_r;
        inst_valid_s = inst_valid_r;
        inst_s       = inst_r;
        inst_pc_s    = inst_pc_r;
        inst_err_s   = inst_err_r;
        fetch_cnt_s  = fetch_cnt_r;
        case (state_r)
            S_IDLE: begin
                // flush is meaningless here; a same-cycle fetch_start still starts
                if (fetch_start) begin
                    req_addr_s = pc;
                    inst_pc_s  = pc;
                    drop_s     = 1'b0;
                    if (pc[1:0] != 2'b00) begin
                        state_s      = S_HOLD;
                        inst_s       = NOP_INST;
                        inst_err_s   = ERR_ALIGN;
                        inst_valid_s = 1'b1;
                    end else begin
                        state_s     = S_REQ;
                        req_valid_s = 1'b1;
                    end
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_REQ: begin
                // The request must complete even when flushed; just remember it.
                drop_s = drop_r | flush;
                if (imem_req_ready) begin
                    state_s     = S_WAIT;
                    req_valid_s = 1'b0;
                    timer_s     = 16'd0;
                end else begin
                    state_s     = S_REQ;
                    req_valid_s = 1'b1;
                end
            end
            S_WAIT: begin
                drop_s  = drop_r | flush;
                timer_s = timer_inc_s[15:0];
                if (imem_rsp_valid || timeout_hit_s) begin
                    if (drop_r || flush) begin
                        state_s = S_IDLE;
                        drop_s  = 1'b0;
                    end else begin
                        state_s      = S_HOLD;
                        inst_valid_s = 1'b1;
                        // A response in the timeout cycle takes priority.
                        if (imem_rsp_valid) begin
                            if (imem_rsp_err) begin
                                inst_s     = NOP_INST;
                                inst_err_s = ERR_BUS;
                            end else begin
                                inst_s     = imem_rsp_data;
                                inst_err_s = ERR_OK;
                            end
                        end else begin
                            inst_s     = NOP_INST;
                            inst_err_s = ERR_TOUT;
                        end
                    end
                end else begin
                    state_s = S_WAIT;
                end
            end
            S_HOLD: begin
                // flush beats a same-cycle handshake: nothing is counted
                if (flush) begin
                    state_s      = S_IDLE;
                    inst_valid_s = 1'b0;
                end else if (inst_ready) begin
                    state_s      = S_IDLE;
                    inst_valid_s = 1'b0;
                    fetch_cnt_s  = fetch_cnt_r + 32'd1;
                end else begin
                    state_s      = S_HOLD;
                    inst_valid_s = 1'b1;
                end
            end
            default: begin
                state_s      = S_IDLE;
                drop_s       = 1'b0;
                req_valid_s  = 1'b0;
                inst_valid_s = 1'b0;
            end
        endcase
        busy_s = (state_s != S_IDLE);
    end

    // State and output registers; reset abandons any fetch in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= S_IDLE;
            drop_r       <= 1'b0;
            timer_r      <= 16'd0;
            req_valid_r  <= 1'b0;
            req_addr_r   <= 32'd0;
            inst_valid_r <= 1'b0;
            inst_r       <= 32'd0;
            inst_pc_r    <= 32'd0;
            inst_err_r   <= 2'd0;
            busy_r       <= 1'b0;
            fetch_cnt_r  <= 32'd0;
        end else begin
            state_r      <= state_s;
            drop_r       <= drop_s;
            timer_r      <= timer_s;
            req_valid_r  <= req_valid_s;
            req_addr_r   <= req_addr_s;
            inst_valid_r <= inst_valid_s;
            inst_r       <= inst_s;
            inst_pc_r    <= inst_pc_s;
            inst_err_r   <= inst_err_s;
            busy_r       <= busy_s;
            fetch_cnt_r  <= fetch_cnt_s;
        end
    end

    assign imem_req_valid = req_valid_r;
    assign imem_req_addr  = req_addr_r;
    assign inst_valid     = inst_valid_r;
    assign inst           = inst_r;
    assign inst_pc        = inst_pc_r;
    assign inst_err       = inst_err_r;
    assign busy           = busy_r;
    assign fetch_cnt      = fetch_cnt_r;

endmodule

// File: tb/tb_ysyx_25020047_ifu.sv
// Directed testbench for the instruction fetch unit (TIMEOUT set to 4).
// Inputs change 1 time unit after the rising edge; registered outputs are
// checked at that point too.
module tb_ysyx_25020047_ifu;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_start;
    logic [31:0] pc;
    logic        flush;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [1:0]  inst_err;
    logic        busy;
    logic [31:0] fetch_cnt;

    int vectors = 0;
    int miscompares = 0;

    ysyx_25020047_ifu #(.TIMEOUT(4), .NOP_INST(32'h00000013)) dut (
        .clk(clk), .rst(rst), .fetch_start(fetch_start), .pc(pc), .flush(flush),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .imem_rsp_err(imem_rsp_err),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
        .inst_pc(inst_pc), .inst_err(inst_err), .busy(busy), .fetch_cnt(fetch_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; fetch_start = 1'b0; pc = 32'd0; flush = 1'b0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'd0;
        imem_rsp_err = 1'b0; inst_ready = 1'b0;
        #2;
        vectors++;
        if ({imem_req_valid, inst_valid, busy, inst_err} !== 5'd0 || imem_req_addr !== 32'd0 ||
            inst !== 32'd0 || inst_pc !== 32'd0 || fetch_cnt !== 32'd0) begin
            miscompares++;
            $display("FAIL reset: got rv=%b iv=%b busy=%b err=%0d addr=%h inst=%h ipc=%h cnt=%0d, exp all zero",
                     imem_req_valid, inst_valid, busy, inst_err, imem_req_addr, inst, inst_pc, fetch_cnt);
        end
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        pc = 32'h80000000; fetch_start = 1'b1; inst_ready = 1'b1;
        tick(); // cycle 1
        fetch_start = 1'b0;
        vectors++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h80000000 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_req: got rv=%b addr=%h busy=%b, exp 1 80000000 1", imem_req_valid, imem_req_addr, busy);
        end
        imem_req_ready = 1'b1;
        tick(); // cycle 2
        imem_req_ready = 1'b0;
        vectors++;
        if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_wait: got rv=%b iv=%b, exp 0 0", imem_req_valid, inst_valid);
        end
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h00100093;
        tick(); // cycle 3
        imem_rsp_valid = 1'b0; imem_rsp_data = 32'd0;
        vectors++;
        if (inst_valid !== 1'b1 || inst !== 32'h00100093 || inst_pc !== 32'h80000000 || inst_err !== 2'd0) begin
            miscompares++;
            $display("FAIL basic_inst: got iv=%b inst=%h pc=%h err=%0d, exp 1 00100093 80000000 0",
                     inst_valid, inst, inst_pc, inst_err);
        end
        tick(); // cycle 4
        vectors++;
        if (inst_valid !== 1'b0 || fetch_cnt !== 32'd1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_done: got iv=%b cnt=%0d busy=%b, exp 0 1 0", inst_valid, fetch_cnt, busy);
        end
    endtask

    task automatic test_misaligned_backpressure();
        pc = 32'h80000002; fetch_start = 1'b1; inst_ready = 1'b0;
        tick();
        fetch_start = 1'b0;
        vectors++;
        if (imem_req_valid !== 1'b0 || inst_valid !== 1'b1 || inst !== 32'h00000013 ||
            inst_err !== 2'd1 || inst_pc !== 32'h80000002) begin
            miscompares++;
            $display("FAIL misaligned: got rv=%b iv=%b inst=%h err=%0d pc=%h, exp 0 1 00000013 1 80000002",
                     imem_req_valid, inst_valid, inst, inst_err, inst_pc);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            vectors++;
            if (inst_valid !== 1'b1 || inst !== 32'h00000013 || inst_err !== 2'd1 ||
                imem_req_valid !== 1'b0 || fetch_cnt !== 32'd1) begin
                miscompares++;
                $display("FAIL backpressure[%0d]: got iv=%b inst=%h err=%0d rv=%b cnt=%0d, exp 1 00000013 1 0 1",
                         i, inst_valid, inst, inst_err, imem_req_valid, fetch_cnt);
            end
        end
        inst_ready = 1'b1;
        tick();
        vectors++;
        if (inst_valid !== 1'b0 || fetch_cnt !== 32'd2) begin
            miscompares++;
            $display("FAIL backpressure_release: got iv=%b cnt=%0d, exp 0 2", inst_valid, fetch_cnt);
        end
    endtask

    task automatic test_bus_error();
        pc = 32'h80000004; fetch_start = 1'b1; inst_ready = 1'b1;
        tick(); fetch_start = 1'b0; imem_req_ready = 1'b1;
        tick(); imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'hdeadbeef; imem_rsp_err = 1'b1;
        tick(); imem_rsp_valid = 1'b0; imem_rsp_err = 1'b0; imem_rsp_data = 32'd0;
        vectors++;
        if (inst_valid !== 1'b1 || inst !== 32'h00000013 || inst_err !== 2'd2 || inst_pc !== 32'h80000004) begin
            miscompares++;
            $display("FAIL bus_error: got iv=%b inst=%h err=%0d pc=%h, exp 1 00000013 2 80000004",
                     inst_valid, inst, inst_err, inst_pc);
        end
        tick();
        vectors++;
        if (fetch_cnt !== 32'd3) begin
            miscompares++;
            $display("FAIL bus_error_cnt: got %0d exp 3", fetch_cnt);
        end
    endtask

    task automatic test_timeout();
        pc = 32'h80000008; fetch_start = 1'b1; inst_ready = 1'b1;
        tick(); fetch_start = 1'b0; imem_req_ready = 1'b1; // cycle 1: acceptance
        tick(); imem_req_ready = 1'b0;                     // cycle 2
        tick();                                            // cycle 3
        tick();                                            // cycle 4
        vectors++;
        if (inst_valid !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_early: got iv=%b busy=%b, exp 0 1", inst_valid, busy);
        end
        tick();                                            // cycle 5
        vectors++;
        if (inst_valid !== 1'b1 || inst !== 32'h00000013 || inst_err !== 2'd3) begin
            miscompares++;
            $display("FAIL timeout: got iv=%b inst=%h err=%0d, exp 1 00000013 3", inst_valid, inst, inst_err);
        end
        tick();
        vectors++;
        if (fetch_cnt !== 32'd4 || inst_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_cnt: got cnt=%0d iv=%b, exp 4 0", fetch_cnt, inst_valid);
        end
    endtask

    task automatic test_flush_wait();
        pc = 32'h8000000c; fetch_start = 1'b1; inst_ready = 1'b1;
        tick(); fetch_start = 1'b0; imem_req_ready = 1'b1;
        tick(); imem_req_ready = 1'b0; flush = 1'b1;       // one cycle after acceptance
        tick(); flush = 1'b0;
        tick(); imem_rsp_valid = 1'b1; imem_rsp_data = 32'h12345678;
        vectors++;
        if (inst_valid !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_wait_pending: got iv=%b busy=%b, exp 0 1", inst_valid, busy);
        end
        tick(); imem_rsp_valid = 1'b0; imem_rsp_data = 32'd0;
        vectors++;
        if (inst_valid !== 1'b0 || busy !== 1'b0 || fetch_cnt !== 32'd4) begin
            miscompares++;
            $display("FAIL flush_wait: got iv=%b busy=%b cnt=%0d, exp 0 0 4", inst_valid, busy, fetch_cnt);
        end
        // follow-up fetch, with a flush in IDLE alongside fetch_start
        pc = 32'h80000010; fetch_start = 1'b1; flush = 1'b1;
        tick(); fetch_start = 1'b0; flush = 1'b0; imem_req_ready = 1'b1;
        vectors++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h80000010) begin
            miscompares++;
            $display("FAIL refetch_req: got rv=%b addr=%h, exp 1 80000010", imem_req_valid, imem_req_addr);
        end
        tick(); imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h00200113;
        tick(); imem_rsp_valid = 1'b0; imem_rsp_data = 32'd0;
        vectors++;
        if (inst_valid !== 1'b1 || inst !== 32'h00200113 || inst_pc !== 32'h80000010 || inst_err !== 2'd0) begin
            miscompares++;
            $display("FAIL refetch_inst: got iv=%b inst=%h pc=%h err=%0d, exp 1 00200113 80000010 0",
                     inst_valid, inst, inst_pc, inst_err);
        end
        tick();
        vectors++;
        if (fetch_cnt !== 32'd5) begin
            miscompares++;
            $display("FAIL refetch_cnt: got %0d exp 5", fetch_cnt);
        end
    endtask

    task automatic test_flush_hold_and_reset();
        pc = 32'h80000006; fetch_start = 1'b1; inst_ready = 1'b0;
        tick(); fetch_start = 1'b0; flush = 1'b1; inst_ready = 1'b1;
        tick(); flush = 1'b0; inst_ready = 1'b0;
        vectors++;
        if (inst_valid !== 1'b0 || busy !== 1'b0 || fetch_cnt !== 32'd5) begin
            miscompares++;
            $display("FAIL flush_hold: got iv=%b busy=%b cnt=%0d, exp 0 0 5", inst_valid, busy, fetch_cnt);
        end
        // reset while waiting for a response
        pc = 32'h80000020; fetch_start = 1'b1;
        tick(); fetch_start = 1'b0; imem_req_ready = 1'b1;
        tick(); imem_req_ready = 1'b0;
        #1 rst = 1'b0;
        #1;
        vectors++;
        if ({imem_req_valid, inst_valid, busy, inst_err} !== 5'd0 || imem_req_addr !== 32'd0 ||
            inst !== 32'd0 || inst_pc !== 32'd0 || fetch_cnt !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_mid: got rv=%b iv=%b busy=%b err=%0d addr=%h inst=%h ipc=%h cnt=%0d, exp all zero",
                     imem_req_valid, inst_valid, busy, inst_err, imem_req_addr, inst, inst_pc, fetch_cnt);
        end
        tick(); rst = 1'b1;
        tick(); imem_rsp_valid = 1'b1; imem_rsp_data = 32'hcafef00d; inst_ready = 1'b1;
        tick(); imem_rsp_valid = 1'b0; imem_rsp_data = 32'd0;
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if (inst_valid !== 1'b0 || busy !== 1'b0 || inst !== 32'd0 || fetch_cnt !== 32'd0) begin
                miscompares++;
                $display("FAIL stray_rsp[%0d]: got iv=%b busy=%b inst=%h cnt=%0d, exp 0 0 0 0",
                         i, inst_valid, busy, inst, fetch_cnt);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_misaligned_backpressure();
        test_bus_error();
        test_timeout();
        test_flush_wait();
        test_flush_hold_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ysyx_25020047_ifu.md
Name: ysyx_25020047_ifu

Overview:
- Instruction fetch unit: takes the current PC from the PC register and issues one word read on the instruction-memory request/response bus.
- Delivers the returned instruction word to the decode stage over a valid/ready handshake.
- Single outstanding fetch, one-entry output hold register, response timeout, and flush support for redirects.
- Sits between the PC register / instruction memory and the decode unit's `inst` input.

Parameters:
- TIMEOUT, 255, WAIT-state cycle limit before the fetch is aborted with an error; legal range 1..65535.
- NOP_INST, 32'h00000013, instruction word presented on any fetch error (addi x0,x0,0).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- fetch_start  in  1  one-cycle pulse: fetch the word at `pc`; honoured only in IDLE.
- pc  in  32  fetch address, sampled when fetch_start is accepted.
- flush  in  1  discard the current or in-flight fetch (redirect).
- imem_req_valid  out  1  request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  32  word address (latched pc).
- imem_rsp_valid  in  1  response valid; one-cycle pulse, no backpressure.
- imem_rsp_data  in  32  response word.
- imem_rsp_err  in  1  bus error with response.
- inst_valid  out  1  instruction available to decode.
- inst_ready  in  1  decode consumes instruction.
- inst  out  32  instruction word.
- inst_pc  out  32  address the instruction was fetched from.
- inst_err  out  2  0 = ok, 1 = misaligned pc, 2 = bus error, 3 = timeout.
- busy  out  1  state != IDLE.
- fetch_cnt  out  32  count of instructions handed to decode; wraps at 2^32.

Behaviour:
- Reset (rst=0, async):
  - State IDLE; drop flag cleared; timer 0; fetch_cnt 0.
  - imem_req_valid, inst_valid, busy = 0; imem_req_addr, inst, inst_pc = 0; inst_err = 0.
  - Reset mid-transaction abandons the fetch. Any later imem response is ignored, because responses are only accepted in WAIT.
- States: IDLE, REQ, WAIT, HOLD. All outputs are registered.
- IDLE, on fetch_start:
  - Latch pc into imem_req_addr and inst_pc.
  - If pc[1:0] != 0: go to HOLD with inst = NOP_INST, inst_err = 1, no bus request.
  - Otherwise go to REQ.
  - fetch_start outside IDLE is ignored. flush in IDLE has no effect; with fetch_start in the same cycle, the fetch starts.
- REQ:
  - imem_req_valid = 1; address stable.
  - imem_req_valid must not drop before imem_req_ready, even on flush.
  - On imem_req_ready: go to WAIT, timer = 0.
  - imem_rsp_valid in REQ is ignored. Responses arrive no earlier than the cycle after acceptance.
- WAIT:
  - Timer increments each cycle.
  - On imem_rsp_valid: latch imem_rsp_data into inst; inst_err = 2 if imem_rsp_err, else 0. On error, inst = NOP_INST. Go to HOLD.
  - If the timer reaches TIMEOUT-1 without a response: inst = NOP_INST, inst_err = 3, go to HOLD.
  - If the response and the timeout occur in the same cycle, the response wins.
- HOLD:
  - inst_valid = 1; inst, inst_pc and inst_err remain stable until handshake.
  - On inst_valid & inst_ready: fetch_cnt += 1, go to IDLE. inst_valid is low the next cycle.
- Flush:
  - In REQ or WAIT: set drop flag. The request still completes. When the response (or timeout) terminates WAIT, go to IDLE with no HOLD and no fetch_cnt increment; drop flag clears.
  - In HOLD: go to IDLE next cycle with no handshake and no count, even if inst_ready is high in the same cycle (flush wins).
- Minimum latency: fetch_start at cycle 0 → imem_req_valid at cycle 1. With ready at 1 and rsp_valid at 2, inst_valid is high at cycle 3.
- Back-to-back throughput is one instruction per 4 cycles minimum.

Test Plan:
- **Basic fetch:** pc=0x80000000, fetch_start; ready at cycle 1, rsp data 0x00100093 at cycle 2, inst_ready held 1 → inst_valid at cycle 3, inst=0x00100093, inst_pc=0x80000000, inst_err=0, fetch_cnt=1.
- **Misaligned pc and backpressure:**
  - pc=0x80000002 → no imem_req_valid; HOLD with inst=0x00000013, inst_err=1.
  - inst_ready low 5 cycles → inst_valid and inst stay constant; fetch_cnt increments once on ready.
- **Bus error and timeout:**
  - rsp_err=1 → inst=0x00000013, inst_err=2.
  - TIMEOUT=4, no response → inst_err=3 exactly 4 cycles after acceptance.
- **Flush in WAIT:** flush one cycle after acceptance, response 2 cycles later → no inst_valid, IDLE after the response, fetch_cnt unchanged. A subsequent fetch_start works normally.
- **Flush in HOLD and reset mid-fetch:**
  - flush with inst_ready=1 in HOLD → no count, IDLE.
  - rst low during WAIT → all outputs 0 immediately; a stray rsp_valid after release is ignored.
